// File: rtl/dac_arbiter.sv
// Two-requester DAC arbiter: grants one sample per DAC frame, then holds off for FRAME_CYCLES.
// Define DAC_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module dac_arbiter #(
    parameter int DATA_W       = 10,
    parameter int FRAME_CYCLES = 64
) (
    input  logic              sysclk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt1,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_ch,
    output logic              dac_load,
    output logic              busy
);

    // state | meaning
    // IDLE  | arbitrating; a grant on this edge captures the winner's sample
    // LOAD  | grant cycle; next edge raises dac_load and arms the frame timer
    // WAIT  | frame timer running down; returns to IDLE at terminal count

    localparam int                CNT_W    = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(FRAME_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic                load_q, load_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                ch_q, ch_d;
    logic                pick1;

`ifdef DAC_ARB_FIXED_PRIO_EN
    assign pick1 = req1 & ~req0;
`else
    logic last_q, last_d;

    // On a tie the requester not granted last wins; reset value 1 lets requester 0 win first.
    assign pick1 = req1 & (~req0 | ~last_q);

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            load_q  <= 1'b0;
            data_q  <= '0;
            ch_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            load_q  <= load_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        load_d  = 1'b0;
        data_d  = data_q;
        ch_d    = ch_q;
`ifndef DAC_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    gnt0_d  = ~pick1;
                    gnt1_d  = pick1;
                    data_d  = pick1 ? data1 : data0;
                    ch_d    = pick1;
`ifndef DAC_ARB_FIXED_PRIO_EN
                    last_d  = pick1;
`endif
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_d  = 1'b1;
                cnt_d   = CNT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign dac_load = load_q;
    assign dac_data = data_q;
    assign dac_ch   = ch_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
